// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between two requesters,
// with burst locking and in-order routing of read data back to the owning requester.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [1:0]          req,
    input  logic [1:0]          lock,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_wren,
    input  logic [DATA_W-1:0]   ram_q
);

    localparam int LastStage = RD_LAT - 1;

    logic              r_ptr;
    logic              r_lockValid;
    logic              r_lockOwner;
    logic [RD_LAT-1:0] r_tagValid;
    logic [RD_LAT-1:0] r_tagId;
    logic [DATA_W-1:0] r_rdataHold;

    logic [1:0]        w_gntRaw;
    logic [1:0]        w_gnt;
    logic [1:0]        w_accept;
    logic              w_anyAccept;
    logic              w_idx;
    logic              w_tailValid;
    logic              w_tailId;

    // A lock only holds while its owner keeps both req and lock asserted
    always_comb begin
        w_gntRaw = 2'b00;
        if (r_lockValid && req[r_lockOwner] && lock[r_lockOwner]) begin
            w_gntRaw[r_lockOwner] = 1'b1;
        end else if (req == 2'b01) begin
            w_gntRaw = 2'b01;
        end else if (req == 2'b10) begin
            w_gntRaw = 2'b10;
        end else if (req == 2'b11) begin
            w_gntRaw = r_ptr ? 2'b10 : 2'b01;
        end
    end

    // Gating with resetn makes the grant and RAM strobes drop the instant reset asserts
    assign w_gnt       = resetn ? w_gntRaw : 2'b00;
    assign gnt         = w_gnt;
    assign w_accept    = req & w_gnt;
    assign w_anyAccept = |w_accept;
    assign w_idx       = w_gnt[1];

    always_comb begin
        ram_address = '0;
        ram_data    = '0;
        ram_wren    = 1'b0;
        if (w_anyAccept) begin
            ram_address = w_idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
            ram_data    = w_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
            ram_wren    = we[w_idx];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_ptr       <= 1'b0;
            r_lockValid <= 1'b0;
            r_lockOwner <= 1'b0;
        end else if (w_anyAccept) begin
            r_ptr       <= ~w_idx;
            r_lockValid <= lock[w_idx];
            r_lockOwner <= w_idx;
        end else begin
            r_lockValid <= 1'b0;
        end
    end

    // Tag pipeline tracks which requester owns the RAM output RD_LAT edges later
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tagValid <= '0;
            r_tagId    <= '0;
        end else begin
            r_tagValid[0] <= w_anyAccept && !we[w_idx];
            r_tagId[0]    <= w_idx;
            for (int j = 1; j < RD_LAT; j++) begin
                r_tagValid[j] <= r_tagValid[j-1];
                r_tagId[j]    <= r_tagId[j-1];
            end
        end
    end

    assign w_tailValid = r_tagValid[LastStage];
    assign w_tailId    = r_tagId[LastStage];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rdataHold <= '0;
        end else if (w_tailValid) begin
            r_rdataHold <= ram_q;
        end
    end

    assign rvalid = w_tailValid ? (w_tailId ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = w_tailValid ? ram_q : r_rdataHold;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: one instance with RD_LAT=1 and one with RD_LAT=2,
// each attached to its own behavioural single-port RAM.
module tb_ram_arbiter;

   logic clock;
   logic resetn;

   logic [1:0]  aReq, aLock, aWe, aGnt, aRvalid;
   logic [15:0] aAddr, aWdata;
   logic [7:0]  aRdata, aRamAddress, aRamData, aRamQ;
   logic        aRamWren;

   logic [1:0]  bReq, bLock, bWe, bGnt, bRvalid;
   logic [15:0] bAddr, bWdata;
   logic [7:0]  bRdata, bRamAddress, bRamData, bRamQ;
   logic        bRamWren;

   logic [7:0] memA [256];
   logic [7:0] memB [256];
   logic [7:0] bRamQStage;

   int nCompared;
   int nMismatched;

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) uDutA (
      .clock(clock), .resetn(resetn), .req(aReq), .lock(aLock), .we(aWe),
      .addr(aAddr), .wdata(aWdata), .gnt(aGnt), .rvalid(aRvalid), .rdata(aRdata),
      .ram_address(aRamAddress), .ram_data(aRamData), .ram_wren(aRamWren), .ram_q(aRamQ)
   );

   ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) uDutB (
      .clock(clock), .resetn(resetn), .req(bReq), .lock(bLock), .we(bWe),
      .addr(bAddr), .wdata(bWdata), .gnt(bGnt), .rvalid(bRvalid), .rdata(bRdata),
      .ram_address(bRamAddress), .ram_data(bRamData), .ram_wren(bRamWren), .ram_q(bRamQ)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single-port RAM with one cycle of read latency
   always @(posedge clock) begin
      if (aRamWren) memA[aRamAddress] <= aRamData;
      aRamQ <= memA[aRamAddress];
   end

   // Single-port RAM with two cycles of read latency
   always @(posedge clock) begin
      if (bRamWren) memB[bRamAddress] <= bRamData;
      bRamQStage <= memB[bRamAddress];
      bRamQ      <= bRamQStage;
   end

   // Advance to just after the next rising edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Reset pulse that stays clear of clock edges
   task automatic applyStimulus_resetPulse();
      aReq = 2'b00; aLock = 2'b00; bReq = 2'b00; bLock = 2'b00;
      resetn = 1'b0;
      #2;
      resetn = 1'b1;
      step();
   endtask

   task automatic test_reset_state();
      #1;
      nCompared++; if (aGnt !== 2'b00) begin nMismatched++; $display("[TB] FAIL resetState.gnt got %b want 00", aGnt); end
      nCompared++; if (aRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL resetState.rvalid got %b want 00", aRvalid); end
      nCompared++; if (aRdata !== 8'h00) begin nMismatched++; $display("[TB] FAIL resetState.rdata got %h want 00", aRdata); end
      nCompared++; if (aRamWren !== 1'b0) begin nMismatched++; $display("[TB] FAIL resetState.ramWren got %b want 0", aRamWren); end
   endtask

   task automatic test_reset();
      aReq = 2'b11; aWe = 2'b11; aAddr = {8'h04, 8'h03}; aWdata = {8'h44, 8'h33};
      #1;
      nCompared++; if (aGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL midTraffic.gnt got %b want 01", aGnt); end
      nCompared++; if (aRamWren !== 1'b1) begin nMismatched++; $display("[TB] FAIL midTraffic.ramWren got %b want 1", aRamWren); end
      resetn = 1'b0;
      #1;
      nCompared++; if (aGnt !== 2'b00) begin nMismatched++; $display("[TB] FAIL asyncReset.gnt got %b want 00", aGnt); end
      nCompared++; if (aRamWren !== 1'b0) begin nMismatched++; $display("[TB] FAIL asyncReset.ramWren got %b want 0", aRamWren); end
      nCompared++; if (aRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL asyncReset.rvalid got %b want 00", aRvalid); end
      aReq = 2'b00; aWe = 2'b00;
      #1;
      resetn = 1'b1;
      step();
   endtask

   task automatic test_write_read();
      aReq = 2'b01; aWe = 2'b01; aAddr = {8'h00, 8'h10}; aWdata = {8'h00, 8'h55};
      #1;
      nCompared++; if (aGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL write.gnt got %b want 01", aGnt); end
      nCompared++; if (aRamWren !== 1'b1) begin nMismatched++; $display("[TB] FAIL write.ramWren got %b want 1", aRamWren); end
      nCompared++; if (aRamAddress !== 8'h10) begin nMismatched++; $display("[TB] FAIL write.ramAddress got %h want 10", aRamAddress); end
      nCompared++; if (aRamData !== 8'h55) begin nMismatched++; $display("[TB] FAIL write.ramData got %h want 55", aRamData); end
      step();
      aReq = 2'b10; aWe = 2'b00; aAddr = {8'h10, 8'h00};
      #1;
      nCompared++; if (aGnt !== 2'b10) begin nMismatched++; $display("[TB] FAIL read.gnt got %b want 10", aGnt); end
      nCompared++; if (aRamWren !== 1'b0) begin nMismatched++; $display("[TB] FAIL read.ramWren got %b want 0", aRamWren); end
      nCompared++; if (aRamAddress !== 8'h10) begin nMismatched++; $display("[TB] FAIL read.ramAddress got %h want 10", aRamAddress); end
      nCompared++; if (aRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL writeNoResp.rvalid got %b want 00", aRvalid); end
      step();
      aReq = 2'b00;
      #1;
      nCompared++; if (aRvalid !== 2'b10) begin nMismatched++; $display("[TB] FAIL readResp.rvalid got %b want 10", aRvalid); end
      nCompared++; if (aRdata !== 8'h55) begin nMismatched++; $display("[TB] FAIL readResp.rdata got %h want 55", aRdata); end
      nCompared++; if (aGnt !== 2'b00) begin nMismatched++; $display("[TB] FAIL idle.gnt got %b want 00", aGnt); end
      step();
      #1;
      nCompared++; if (aRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL onePulse.rvalid got %b want 00", aRvalid); end
      nCompared++; if (aRdata !== 8'h55) begin nMismatched++; $display("[TB] FAIL hold.rdata got %h want 55", aRdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0] expGnt;
      logic [1:0] expRvalid;
      applyStimulus_resetPulse();
      aReq = 2'b11; aWe = 2'b00; aLock = 2'b00; aAddr = {8'h10, 8'h10};
      for (int i = 0; i < 4; i++) begin
         expGnt    = (i % 2 == 0) ? 2'b01 : 2'b10;
         expRvalid = (i == 0) ? 2'b00 : ((i % 2 == 1) ? 2'b01 : 2'b10);
         #1;
         nCompared++; if (aGnt !== expGnt) begin nMismatched++; $display("[TB] FAIL roundRobin[%0d].gnt got %b want %b", i, aGnt, expGnt); end
         nCompared++; if (aRvalid !== expRvalid) begin nMismatched++; $display("[TB] FAIL roundRobin[%0d].rvalid got %b want %b", i, aRvalid, expRvalid); end
         if (i > 0) begin
            nCompared++; if (aRdata !== 8'h55) begin nMismatched++; $display("[TB] FAIL roundRobin[%0d].rdata got %h want 55", i, aRdata); end
         end
         step();
      end
      aReq = 2'b00;
      #1;
      nCompared++; if (aRvalid !== 2'b10) begin nMismatched++; $display("[TB] FAIL roundRobinTail.rvalid got %b want 10", aRvalid); end
      step();
   endtask

   task automatic test_lock();
      logic [1:0] expRvalid;
      applyStimulus_resetPulse();
      aReq = 2'b11; aWe = 2'b00; aLock = 2'b01; aAddr = {8'h10, 8'h10};
      for (int i = 0; i < 4; i++) begin
         expRvalid = (i == 0) ? 2'b00 : 2'b01;
         #1;
         nCompared++; if (aGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL lock[%0d].gnt got %b want 01", i, aGnt); end
         nCompared++; if (aRvalid !== expRvalid) begin nMismatched++; $display("[TB] FAIL lock[%0d].rvalid got %b want %b", i, aRvalid, expRvalid); end
         step();
      end
      aLock = 2'b00;
      #1;
      nCompared++; if (aGnt !== 2'b10) begin nMismatched++; $display("[TB] FAIL unlock.gnt got %b want 10", aGnt); end
      nCompared++; if (aRvalid !== 2'b01) begin nMismatched++; $display("[TB] FAIL unlock.rvalid got %b want 01", aRvalid); end
      step();
      aReq = 2'b00;
      #1;
      nCompared++; if (aRvalid !== 2'b10) begin nMismatched++; $display("[TB] FAIL unlockTail.rvalid got %b want 10", aRvalid); end
      nCompared++; if (aRdata !== 8'h55) begin nMismatched++; $display("[TB] FAIL unlockTail.rdata got %h want 55", aRdata); end
      step();
   endtask

   task automatic test_rd_lat2();
      applyStimulus_resetPulse();
      bReq = 2'b01; bWe = 2'b01; bAddr = {8'h00, 8'h01}; bWdata = {8'h00, 8'hA1};
      step();
      bReq = 2'b10; bWe = 2'b10; bAddr = {8'h02, 8'h00}; bWdata = {8'hB2, 8'h00};
      step();
      bReq = 2'b11; bWe = 2'b00; bAddr = {8'h02, 8'h01};
      #1;
      nCompared++; if (bGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL lat2.c0.gnt got %b want 01", bGnt); end
      step();
      #1;
      nCompared++; if (bGnt !== 2'b10) begin nMismatched++; $display("[TB] FAIL lat2.c1.gnt got %b want 10", bGnt); end
      nCompared++; if (bRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL lat2.c1.rvalid got %b want 00", bRvalid); end
      step();
      bReq = 2'b00;
      #1;
      nCompared++; if (bRvalid !== 2'b01) begin nMismatched++; $display("[TB] FAIL lat2.c2.rvalid got %b want 01", bRvalid); end
      nCompared++; if (bRdata !== 8'hA1) begin nMismatched++; $display("[TB] FAIL lat2.c2.rdata got %h want a1", bRdata); end
      step();
      #1;
      nCompared++; if (bRvalid !== 2'b10) begin nMismatched++; $display("[TB] FAIL lat2.c3.rvalid got %b want 10", bRvalid); end
      nCompared++; if (bRdata !== 8'hB2) begin nMismatched++; $display("[TB] FAIL lat2.c3.rdata got %h want b2", bRdata); end
      step();
      #1;
      nCompared++; if (bRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL lat2.c4.rvalid got %b want 00", bRvalid); end
      nCompared++; if (bRdata !== 8'hB2) begin nMismatched++; $display("[TB] FAIL lat2.c4.rdata got %h want b2", bRdata); end
      step();
   endtask

   task automatic test_reset_flush();
      applyStimulus_resetPulse();
      bReq = 2'b01; bWe = 2'b00; bAddr = {8'h02, 8'h01};
      #1;
      nCompared++; if (bGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL flush.accept.gnt got %b want 01", bGnt); end
      step();
      bReq = 2'b00;
      #1;
      nCompared++; if (bRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL flush.inFlight.rvalid got %b want 00", bRvalid); end
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         nCompared++; if (bRvalid !== 2'b00) begin nMismatched++; $display("[TB] FAIL flush.after[%0d].rvalid got %b want 00", i, bRvalid); end
         step();
      end
      bReq = 2'b11;
      #1;
      nCompared++; if (bGnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL flush.pointer.gnt got %b want 01", bGnt); end
      bReq = 2'b00;
      step();
   endtask

   initial begin
      nCompared = 0;
      nMismatched = 0;
      resetn = 1'b0;
      aReq = 2'b00; aLock = 2'b00; aWe = 2'b00; aAddr = '0; aWdata = '0;
      bReq = 2'b00; bLock = 2'b00; bWe = 2'b00; bAddr = '0; bWdata = '0;
      test_reset_state();
      step();
      step();
      resetn = 1'b1;
      step();
      test_reset();
      test_write_read();
      test_round_robin();
      test_lock();
      test_rd_lat2();
      test_reset_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
